// File: rtl/fphub_pkg.sv
// Shared types and helpers for the FPHUB adder front end.
// Holds the alignment FSM state encoding and the per-cycle shift-amount helper.
package fphub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } align_state_t;

    function automatic int unsigned min_shift(input int unsigned rem, input int unsigned step);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/Exponent_difference.sv
// Signed exponent difference Ex - Ey over E+1 bits.
// Both exponents are zero-extended before subtracting, so bit E carries the sign.
module Exponent_difference #(
    parameter int E = 8
) (
    input  logic [E-1:0] Ex,
    input  logic [E-1:0] Ey,
    output logic [E:0]   dif
);

    assign dif = {1'b0, Ex} - {1'b0, Ey};

endmodule

// File: rtl/fphub_align_sequencer.sv
// Multi-cycle operand alignment for the FPHUB adder: orders the pair by exponent and
// right-shifts the smaller significand at most SHIFT_STEP bits per cycle.
module fphub_align_sequencer
    import fphub_pkg::*;
#(
    parameter int E          = 8,
    parameter int M          = 24,
    parameter int SHIFT_STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E-1:0] Ex,
    input  logic [E-1:0] Ey,
    input  logic [M-1:0] Mx,
    input  logic [M-1:0] My,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E-1:0] out_Emax,
    output logic [M-1:0] out_Mmax,
    output logic [M-1:0] out_Mmin,
    output logic         out_swap,
    output logic         out_flush,
    output align_state_t dbg_state
);

    localparam int CW = $clog2(M + 1);

    // Handshakes: a pair moves when valid and ready are both high on a rising edge.
    // Upstream may not rely on in_valid being seen unless in_ready is high that cycle;
    // the aligned pair is held unchanged while out_valid=1 and out_ready=0.

    align_state_t   state_q;
    logic           out_valid_q;
    logic [E-1:0]   emax_q;
    logic [M-1:0]   mmax_q;
    logic [M-1:0]   mmin_q;
    logic           swap_q;
    logic           flush_q;
    logic [CW-1:0]  rem_q;

    logic [E:0]     dif;
    logic           swap_d;
    logic [E-1:0]   abs_dif_d;
    logic           flush_d;
    logic           accept;
    logic [CW-1:0]  sh_amt;
    logic [M-1:0]   mmin_d;
    logic [CW-1:0]  rem_d;

    Exponent_difference #(.E(E)) u_exp_dif (
        .Ex  (Ex),
        .Ey  (Ey),
        .dif (dif)
    );

    assign swap_d    = dif[E];
    assign abs_dif_d = swap_d ? E'(-dif) : E'(dif);
    assign flush_d   = (32'(abs_dif_d) >= 32'(M));

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // The last ALIGN cycle shifts only the residual, so |dif| is matched exactly.
    assign sh_amt = CW'(min_shift(32'(rem_q), int'(SHIFT_STEP)));
    assign mmin_d = mmin_q >> sh_amt;
    assign rem_d  = rem_q - sh_amt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            emax_q      <= '0;
            mmax_q      <= '0;
            mmin_q      <= '0;
            swap_q      <= 1'b0;
            flush_q     <= 1'b0;
            rem_q       <= '0;
        end else if (accept) begin
            emax_q  <= swap_d ? Ey : Ex;
            mmax_q  <= swap_d ? My : Mx;
            mmin_q  <= flush_d ? '0 : (swap_d ? Mx : My);
            swap_q  <= swap_d;
            flush_q <= flush_d;
            rem_q   <= flush_d ? '0 : CW'(abs_dif_d);
            if (flush_d || (abs_dif_d == '0)) begin
                state_q     <= DONE;
                out_valid_q <= 1'b1;
            end else begin
                state_q     <= ALIGN;
                out_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ALIGN: begin
                    mmin_q <= mmin_d;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_Emax  = emax_q;
    assign out_Mmax  = mmax_q;
    assign out_Mmin  = mmin_q;
    assign out_swap  = swap_q;
    assign out_flush = flush_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fphub_align_sequencer.sv
// Directed bench for fphub_align_sequencer with E=8, M=24, SHIFT_STEP=4.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_fphub_align_sequencer;
    import fphub_pkg::*;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   Ex;
    logic [7:0]   Ey;
    logic [23:0]  Mx;
    logic [23:0]  My;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_Emax;
    logic [23:0]  out_Mmax;
    logic [23:0]  out_Mmin;
    logic         out_swap;
    logic         out_flush;
    align_state_t dbg_state;

    int checks;
    int errors;

    fphub_align_sequencer #(.E(8), .M(24), .SHIFT_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ex        (Ex),
        .Ey        (Ey),
        .Mx        (Mx),
        .My        (My),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Emax  (out_Emax),
        .out_Mmax  (out_Mmax),
        .out_Mmin  (out_Mmin),
        .out_swap  (out_swap),
        .out_flush (out_flush),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        Ex = '0; Ey = '0; Mx = '0; My = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     dbg_state, out_valid, in_ready);
        end
        checks++;
        if (out_Emax !== 8'd0 || out_Mmax !== 24'd0 || out_Mmin !== 24'd0 ||
            out_swap !== 1'b0 || out_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: Emax=%h Mmax=%h Mmin=%h swap=%b flush=%b, want all 0",
                     out_Emax, out_Mmax, out_Mmin, out_swap, out_flush);
        end
    endtask

    // Accepts one pair, scrambles the inputs (with in_valid held high) while the block is
    // busy, then checks latency, the aligned pair and backpressure, and pops the result.
    task automatic run_pair(input logic [7:0] ex, input logic [7:0] ey,
                            input logic [23:0] mx, input logic [23:0] my,
                            input logic [7:0] e_emax, input logic [23:0] e_mmax,
                            input logic [23:0] e_mmin, input logic e_swap,
                            input logic e_flush, input int e_lat, input string name);
        int n;
        int lat;
        @(negedge clk);
        Ex = ex; Ey = ey; Mx = mx; My = my;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s_accept: in_ready=%b after %0d cycles, want 1", name, in_ready, n);
        end
        @(posedge clk);
        #1;
        Ex = 8'($urandom); Ey = 8'($urandom); Mx = 24'($urandom); My = 24'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== e_lat || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b in cycle %0d, want 1 in cycle %0d",
                     name, out_valid, lat, e_lat);
        end
        checks++;
        if (out_Emax !== e_emax || out_Mmax !== e_mmax || out_Mmin !== e_mmin) begin
            errors++;
            $display("FAIL %s_data: Emax=%0d Mmax=%h Mmin=%h, want %0d %h %h",
                     name, out_Emax, out_Mmax, out_Mmin, e_emax, e_mmax, e_mmin);
        end
        checks++;
        if (out_swap !== e_swap || out_flush !== e_flush) begin
            errors++;
            $display("FAIL %s_flags: swap=%b flush=%b, want %b %b",
                     name, out_swap, out_flush, e_swap, e_flush);
        end
        checks++;
        if (in_ready !== 1'b0 || dbg_state !== DONE) begin
            errors++;
            $display("FAIL %s_hold: in_ready=%b state=%0d, want 0 and DONE",
                     name, in_ready, dbg_state);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL %s_pop: out_valid=%b state=%0d, want 0 and IDLE",
                     name, out_valid, dbg_state);
        end
    endtask

    task automatic test_align();
        run_pair(8'd13, 8'd7, 24'hC00000, 24'h800000, 8'd13, 24'hC00000, 24'h020000, 1'b0, 1'b0, 3, "x_larger");
        run_pair(8'd7, 8'd13, 24'hC00000, 24'h800000, 8'd13, 24'h800000, 24'h030000, 1'b1, 1'b0, 3, "y_larger");
        run_pair(8'd21, 8'd16, 24'h111111, 24'hF0F0F0, 8'd21, 24'h111111, 24'h078787, 1'b0, 1'b0, 3, "dif5");
        run_pair(8'd10, 8'd33, 24'hFFFFFF, 24'h400000, 8'd33, 24'h400000, 24'h000001, 1'b1, 1'b0, 7, "dif23_max");
    endtask

    task automatic test_equal();
        run_pair(8'd13, 8'd13, 24'hC00000, 24'h800000, 8'd13, 24'hC00000, 24'h800000, 1'b0, 1'b0, 1, "equal");
    endtask

    task automatic test_flush();
        run_pair(8'd200, 8'd10, 24'hABCDEF, 24'h123456, 8'd200, 24'hABCDEF, 24'h000000, 1'b0, 1'b1, 1, "flush190");
        run_pair(8'd40, 8'd16, 24'h800000, 24'hFFFFFF, 8'd40, 24'h800000, 24'h000000, 1'b0, 1'b1, 1, "flush24");
        run_pair(8'd0, 8'd255, 24'hAAAAAA, 24'h555555, 8'd255, 24'h555555, 24'h000000, 1'b1, 1'b1, 1, "flush255");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        Ex = 8'd13; Ey = 8'd7; Mx = 24'hC00000; My = 24'h800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_Emax !== 8'd13 ||
                out_Mmax !== 24'hC00000 || out_Mmin !== 24'h020000 || out_swap !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b in_ready=%b Emax=%0d Mmax=%h Mmin=%h swap=%b, want 1 0 13 c00000 020000 0",
                         i, out_valid, in_ready, out_Emax, out_Mmax, out_Mmin, out_swap);
            end
            @(negedge clk);
        end
        Ex = 8'd20; Ey = 8'd20; Mx = 24'h654321; My = 24'h123456;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_Emax !== 8'd20 || out_Mmax !== 24'h654321 ||
            out_Mmin !== 24'h123456 || out_swap !== 1'b0 || out_flush !== 1'b0) begin
            errors++;
            $display("FAIL b2b_data: valid=%b Emax=%0d Mmax=%h Mmin=%h swap=%b flush=%b, want 1 20 654321 123456 0 0",
                     out_valid, out_Emax, out_Mmax, out_Mmin, out_swap, out_flush);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        Ex = 8'd30; Ey = 8'd10; Mx = 24'hFFFFFF; My = 24'hFFFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dbg_state !== ALIGN) begin
            errors++;
            $display("FAIL rmid_align: state=%0d in 2nd ALIGN cycle, want ALIGN", dbg_state);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_state: state=%0d out_valid=%b in_ready=%b, want IDLE 0 1",
                     dbg_state, out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rmid_stale: out_valid seen %0d cycles after reset, want 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_align();
        test_equal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        run_pair(8'd9, 8'd5, 24'h800000, 24'hF00000, 8'd9, 24'h800000, 24'h0F0000, 1'b0, 1'b0, 2, "post_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
